// File: rtl/nor_unit_seq.sv
// Sequential normalizer for the SD4 MAC adder->normalizer stage.
// Shifts the sum magnitude one bit per cycle until bit HP holds the leading one, then packs the result.
module nor_unit_seq #(
  parameter int unsigned SUM_W = 20,
  parameter int unsigned EXP_W = 6,
  parameter int unsigned MAN_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] signed_sum_in,
  input  logic [EXP_W-1:0] exp_max_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign_out,
  output logic [EXP_W-1:0] exp_out,
  output logic [MAN_W-1:0] man_out,
  output logic             ovf_out,
  output logic             unf_out,
  output logic             zero_out
);

  localparam int unsigned HP = SUM_W - 3;
  localparam logic signed [EXP_W+1:0] EOne = 1;
  localparam logic signed [EXP_W+1:0] EMax = signed'({2'b00, {EXP_W{1'b1}}});

  typedef enum logic [1:0] {StIdle, StNorm, StOut} state_e;

  state_e                  r_state;
  logic [SUM_W-1:0]        r_mag;
  logic signed [EXP_W+1:0] r_e;
  logic                    r_sgn;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic                    r_sign;
  logic [EXP_W-1:0]        r_exp;
  logic [MAN_W-1:0]        r_man;
  logic                    r_ovf;
  logic                    r_unf;
  logic                    r_zero;

  logic [SUM_W-1:0]        w_mag_in;
  logic                    w_mag_zero;
  logic                    w_mag_high;
  logic                    w_e_ovf;
  logic                    w_e_unf;

  // |-2^(SUM_W-1)| wraps to itself, which is the correct unsigned magnitude.
  assign w_mag_in   = signed_sum_in[SUM_W-1] ? (~signed_sum_in + SUM_W'(1)) : signed_sum_in;
  assign w_mag_zero = (r_mag == '0);
  assign w_mag_high = |r_mag[SUM_W-1:HP+1];
  assign w_e_ovf    = (r_e > EMax);
  assign w_e_unf    = r_e[EXP_W+1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_mag       <= '0;
      r_e         <= '0;
      r_sgn       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_sign      <= 1'b0;
      r_exp       <= '0;
      r_man       <= '0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid && r_in_ready) begin
            r_sgn      <= signed_sum_in[SUM_W-1];
            r_mag      <= w_mag_in;
            r_e        <= signed'({2'b00, exp_max_in});
            r_in_ready <= 1'b0;
            r_state    <= StNorm;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        StNorm: begin
          if (w_mag_zero) begin
            r_sign      <= 1'b0;
            r_exp       <= '0;
            r_man       <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_zero      <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= StOut;
          end else if (w_mag_high) begin
            r_mag <= r_mag >> 1;
            r_e   <= r_e + EOne;
          end else if (!r_mag[HP]) begin
            r_mag <= r_mag << 1;
            r_e   <= r_e - EOne;
          end else begin
            r_zero      <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= StOut;
            if (w_e_ovf) begin
              r_sign <= r_sgn;
              r_exp  <= '1;
              r_man  <= '1;
              r_ovf  <= 1'b1;
              r_unf  <= 1'b0;
            end else if (w_e_unf) begin
              r_sign <= 1'b0;
              r_exp  <= '0;
              r_man  <= '0;
              r_ovf  <= 1'b0;
              r_unf  <= 1'b1;
            end else begin
              r_sign <= r_sgn;
              r_exp  <= r_e[EXP_W-1:0];
              // Truncation: bits below the mantissa window are dropped.
              r_man  <= r_mag[HP-1 -: MAN_W];
              r_ovf  <= 1'b0;
              r_unf  <= 1'b0;
            end
          end
        end
        StOut: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: begin
          r_state     <= StIdle;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sign_out  = r_sign;
  assign exp_out   = r_exp;
  assign man_out   = r_man;
  assign ovf_out   = r_ovf;
  assign unf_out   = r_unf;
  assign zero_out  = r_zero;

endmodule
